// File: rtl/stopwatch_core.sv
// Stopwatch / countdown core: 4-digit BCD SS.cc driven by a synchronised ~100 Hz tick used as data.
// Outputs registered, one clk after the causing event; tick_evt lands SYNC_STAGES+1 clks after tick_in rises.
module stopwatch_core #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] UP_LIMIT    = 16'h9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        mode,
    input  logic        load_en,
    input  logic [15:0] load_value,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        done_pulse
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] tick_sync;
    logic                   tick_hist;
    logic                   tick_evt;
    logic                   dir, dir_eff;
    logic [15:0]            load_reg, load_reg_nx;
    logic [15:0]            digits_nx;
    logic [15:0]            step_val;
    logic [15:0]            end_val;
    logic                   at_end;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] > 4'd9) begin
                r[i*4 +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // tick_in is asynchronous to clk: synchronise, then detect its rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_sync <= '0;
            tick_hist <= 1'b0;
            tick_evt  <= 1'b0;
        end else begin
            tick_sync <= {tick_sync[SYNC_STAGES-2:0], tick_in};
            tick_hist <= tick_sync[SYNC_STAGES-1];
            tick_evt  <= tick_sync[SYNC_STAGES-1] & ~tick_hist;
        end
    end

    // Direction follows mode only while idle; frozen for the rest of a run
    assign dir_eff = (state == S_IDLE) ? mode : dir;

    always_comb begin
        step_val = dir_eff ? bcd_dec(digits) : bcd_inc(digits);
        end_val  = dir_eff ? 16'h0000 : UP_LIMIT;
        at_end   = dir_eff ? (digits == 16'h0000) : (digits >= UP_LIMIT);
    end

    always_comb begin
        state_nx    = state;
        digits_nx   = digits;
        load_reg_nx = load_reg;

        if (clear) begin
            state_nx  = S_IDLE;
            digits_nx = dir ? load_reg : 16'h0000;
        end else if (load_en && (state == S_IDLE || state == S_PAUSE)) begin
            load_reg_nx = bcd_clamp(load_value);
            digits_nx   = bcd_clamp(load_value);
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_stop) begin
                        state_nx = (dir_eff && digits == 16'h0000) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (start_stop) begin
                        state_nx = S_PAUSE;
                    end else if (tick_evt) begin
                        // Already at the terminal value (e.g. loaded there): finish without wrapping
                        if (at_end) begin
                            state_nx = S_DONE;
                        end else begin
                            digits_nx = step_val;
                            if (step_val == end_val) begin
                                state_nx = S_DONE;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        state_nx = S_RUN;
                    end
                end
                S_DONE: begin
                    state_nx = S_DONE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits     <= 16'h0000;
            load_reg   <= 16'h0000;
            dir        <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            digits     <= digits_nx;
            load_reg   <= load_reg_nx;
            dir        <= dir_eff;
            running    <= (state_nx == S_RUN);
            done       <= (state_nx == S_DONE);
            done_pulse <= (state_nx == S_DONE) && (state != S_DONE);
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: vector table, directed corner sequences, random ops vs. an integer model.
module tb_stopwatch_core;

    localparam int OP_CLEAR = 0;
    localparam int OP_LOAD  = 1;
    localparam int OP_START = 2;
    localparam int OP_TICK  = 3;
    localparam int OP_MODE  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct {
        int          op;
        logic [15:0] val;
        logic [15:0] exp_dig;
        logic        exp_run;
        logic        exp_done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_in = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        mode = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        done_pulse;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulse_cnt = 0;

    vec_t vecs[$];

    // model state: time as a plain integer number of centiseconds
    int m_state, m_t, m_load, m_done_cnt;
    bit m_dir, m_mode;

    stopwatch_core #(.SYNC_STAGES(2), .UP_LIMIT(16'h9999)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .mode       (mode),
        .load_en    (load_en),
        .load_value (load_value),
        .digits     (digits),
        .running    (running),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_pulse) pulse_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {14'd0, digits, running, done};
    endfunction

    function automatic logic [31:0] pack(input logic [15:0] d, input logic r, input logic dn);
        return {14'd0, d, r, dn};
    endfunction

    function automatic int bcd_to_int(input logic [15:0] v);
        int n, acc;
        acc = 0;
        for (int i = 3; i >= 0; i--) begin
            n = int'(v[i*4 +: 4]);
            if (n > 9) n = 9;
            acc = acc * 10 + n;
        end
        return acc;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int t);
        logic [15:0] r;
        r[15:12] = 4'((t / 1000) % 10);
        r[11:8]  = 4'((t / 100) % 10);
        r[7:4]   = 4'((t / 10) % 10);
        r[3:0]   = 4'(t % 10);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_state = M_IDLE; m_t = 0; m_load = 0; m_dir = m_mode;
    endtask

    task automatic pulse(input int op, input logic [15:0] val);
        @(posedge clk);
        #1;
        case (op)
            OP_CLEAR: clear = 1'b1;
            OP_LOAD:  begin load_en = 1'b1; load_value = val; end
            default:  start_stop = 1'b1;
        endcase
        @(posedge clk);
        #1;
        clear = 1'b0; load_en = 1'b0; start_stop = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_tick(input int high_clks);
        @(posedge clk);
        #1 tick_in = 1'b1;
        repeat (high_clks) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic do_op(input int op, input logic [15:0] val);
        if (op == OP_TICK) begin
            do_tick(4);
        end else if (op == OP_MODE) begin
            @(posedge clk);
            #1 mode = val[0];
            repeat (2) @(posedge clk);
        end else begin
            pulse(op, val);
        end
    endtask

    // Reference behaviour expressed on integer time and an abstract state number
    task automatic model_op(input int op, input logic [15:0] val);
        case (op)
            OP_CLEAR: begin
                m_t = m_dir ? m_load : 0;
                m_state = M_IDLE;
                m_dir = m_mode;
            end
            OP_MODE: begin
                m_mode = val[0];
                if (m_state == M_IDLE) m_dir = m_mode;
            end
            OP_LOAD: begin
                if (m_state == M_IDLE || m_state == M_PAUSE) begin
                    m_load = bcd_to_int(val);
                    m_t = m_load;
                end
            end
            OP_START: begin
                if (m_state == M_IDLE) begin
                    if (m_dir && m_t == 0) begin m_state = M_DONE; m_done_cnt++; end
                    else m_state = M_RUN;
                end else if (m_state == M_RUN) m_state = M_PAUSE;
                else if (m_state == M_PAUSE) m_state = M_RUN;
            end
            default: begin
                if (m_state == M_RUN) begin
                    if (m_dir) begin
                        if (m_t > 0) m_t = m_t - 1;
                        if (m_t == 0) begin m_state = M_DONE; m_done_cnt++; end
                    end else begin
                        if (m_t < 9999) m_t = m_t + 1;
                        if (m_t >= 9999) begin m_state = M_DONE; m_done_cnt++; end
                    end
                end
            end
        endcase
    endtask

    task automatic add(input int op, input logic [15:0] val, input logic [15:0] d,
                       input logic r, input logic dn);
        vec_t v;
        v.op = op; v.val = val; v.exp_dig = d; v.exp_run = r; v.exp_done = dn;
        vecs.push_back(v);
    endtask

    initial begin
        int base, op, r;
        logic [15:0] val;

        m_mode = 1'b0; m_done_cnt = 0;

        // reset state
        do_reset();
        @(negedge clk);
        check("reset_state", {14'd0, digits, running, done} | {31'd0, done_pulse}, 32'd0);

        // reset mid-RUN at 05.37
        do_op(OP_MODE, 16'h0);
        do_op(OP_LOAD, 16'h0530);
        do_op(OP_START, 16'h0);
        for (int i = 0; i < 7; i++) do_op(OP_TICK, 16'h0);
        @(negedge clk);
        check("pre_reset_0537", outs(), pack(16'h0537, 1'b1, 1'b0));
        #2 rst = 1'b1;
        #1 check("async_reset", {14'd0, digits, running, done} | {31'd0, done_pulse}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_release", outs(), pack(16'h0000, 1'b0, 1'b0));
        do_op(OP_MODE, 16'h1);
        do_op(OP_CLEAR, 16'h0);
        @(negedge clk);
        check("load_reg_reset", outs(), pack(16'h0000, 1'b0, 1'b0));

        // 101 ticks up, then pause ignores ticks
        m_mode = 1'b0; mode = 1'b0;
        do_reset();
        do_op(OP_START, 16'h0);
        for (int i = 0; i < 101; i++) do_op(OP_TICK, 16'h0);
        @(negedge clk);
        check("up_101", outs(), pack(16'h0101, 1'b1, 1'b0));
        do_op(OP_START, 16'h0);
        @(negedge clk);
        check("pause", outs(), pack(16'h0101, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) do_op(OP_TICK, 16'h0);
        @(negedge clk);
        check("pause_ticks", outs(), pack(16'h0101, 1'b0, 1'b0));

        // start_stop coinciding with tick_evt drops the tick; long tick_in counts once
        do_reset();
        do_op(OP_START, 16'h0);
        @(posedge clk);
        #1 tick_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 start_stop = 1'b1;
        @(posedge clk);
        #1 start_stop = 1'b0;
        repeat (3) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("coincide_pause", outs(), pack(16'h0000, 1'b0, 1'b0));
        do_op(OP_START, 16'h0);
        do_tick(10);
        @(negedge clk);
        check("long_tick_once", outs(), pack(16'h0001, 1'b1, 1'b0));

        // vector table
        do_reset();
        base = pulse_cnt;
        add(OP_MODE,  16'h0001, 16'h0000, 0, 0);
        add(OP_LOAD,  16'h0003, 16'h0003, 0, 0);
        add(OP_START, 16'h0000, 16'h0003, 1, 0);
        add(OP_TICK,  16'h0000, 16'h0002, 1, 0);
        add(OP_TICK,  16'h0000, 16'h0001, 1, 0);
        add(OP_TICK,  16'h0000, 16'h0000, 0, 1);
        add(OP_TICK,  16'h0000, 16'h0000, 0, 1);
        add(OP_START, 16'h0000, 16'h0000, 0, 1);
        add(OP_LOAD,  16'h1234, 16'h0000, 0, 1);
        add(OP_CLEAR, 16'h0000, 16'h0003, 0, 0);
        add(OP_LOAD,  16'h1A9F, 16'h1999, 0, 0);
        add(OP_START, 16'h0000, 16'h1999, 1, 0);
        add(OP_LOAD,  16'h0500, 16'h1999, 1, 0);
        add(OP_TICK,  16'h0000, 16'h1998, 1, 0);
        add(OP_START, 16'h0000, 16'h1998, 0, 0);
        add(OP_TICK,  16'h0000, 16'h1998, 0, 0);
        add(OP_LOAD,  16'h2000, 16'h2000, 0, 0);
        add(OP_START, 16'h0000, 16'h2000, 1, 0);
        add(OP_TICK,  16'h0000, 16'h1999, 1, 0);
        add(OP_CLEAR, 16'h0000, 16'h2000, 0, 0);
        add(OP_MODE,  16'h0000, 16'h2000, 0, 0);
        add(OP_CLEAR, 16'h0000, 16'h0000, 0, 0);
        add(OP_LOAD,  16'h9998, 16'h9998, 0, 0);
        add(OP_START, 16'h0000, 16'h9998, 1, 0);
        add(OP_TICK,  16'h0000, 16'h9999, 0, 1);
        add(OP_CLEAR, 16'h0000, 16'h0000, 0, 0);
        add(OP_LOAD,  16'h0099, 16'h0099, 0, 0);
        add(OP_START, 16'h0000, 16'h0099, 1, 0);
        add(OP_TICK,  16'h0000, 16'h0100, 1, 0);
        add(OP_START, 16'h0000, 16'h0100, 0, 0);
        add(OP_LOAD,  16'h0999, 16'h0999, 0, 0);
        add(OP_START, 16'h0000, 16'h0999, 1, 0);
        add(OP_TICK,  16'h0000, 16'h1000, 1, 0);
        add(OP_MODE,  16'h0001, 16'h1000, 1, 0);
        add(OP_TICK,  16'h0000, 16'h1001, 1, 0);
        add(OP_CLEAR, 16'h0000, 16'h0000, 0, 0);
        add(OP_START, 16'h0000, 16'h0000, 0, 1);
        add(OP_CLEAR, 16'h0000, 16'h0999, 0, 0);
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].val);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), pack(vecs[i].exp_dig, vecs[i].exp_run, vecs[i].exp_done));
        end
        check("table_done_pulses", 32'(pulse_cnt - base), 32'd3);

        // random operations against the integer model
        m_mode = 1'b0; mode = 1'b0;
        do_reset();
        m_done_cnt = 0;
        base = pulse_cnt;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            val = 16'($urandom);
            if (r < 50) op = OP_TICK;
            else if (r < 68) op = OP_START;
            else if (r < 74) op = OP_CLEAR;
            else if (r < 88) op = OP_LOAD;
            else op = OP_MODE;
            if (op == OP_LOAD) begin
                case ($urandom_range(0, 2))
                    0: val = 16'($urandom);
                    1: val = {12'h000, 4'($urandom_range(0, 15))};
                    default: val = {12'h999, 4'($urandom_range(0, 15))};
                endcase
            end
            do_op(op, val);
            model_op(op, val);
            @(negedge clk);
            check($sformatf("rand%0d_op%0d", n, op), outs(),
                  pack(int_to_bcd(m_t), m_state == M_RUN, m_state == M_DONE));
        end
        check("rand_done_pulses", 32'(pulse_cnt - base), 32'(m_done_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
